// File: rtl/tx_pkt_scheduler_pkg.sv
// Shared TX-path definitions for the transmit scheduler and the packetizer.
//   - state_t   : one-hot scheduler state encoding
//   - hdr_t     : latched per-packet header (length in bits, modulation flag)
//   - beats_of(): payload bits -> AXIS beats (BPSK 1 bit/beat, QPSK 2 bits/beat)
//   - GAP_CYCLES_DEF : default idle gap after packet completion
package tx_pkt_scheduler_pkg;

    localparam int LEN_W          = 16;
    localparam int GAP_CYCLES_DEF = 4;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_LOAD   = 5'b00010,
        ST_STREAM = 5'b00100,
        ST_DRAIN  = 5'b01000,
        ST_GAP    = 5'b10000
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             is_bpsk;
    } hdr_t;

    // QPSK carries two payload bits per symbol beat; an odd trailing bit is dropped.
    function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len_bits,
                                                  input logic             is_bpsk);
        return is_bpsk ? len_bits : {1'b0, len_bits[LEN_W-1:1]};
    endfunction

endpackage

// File: rtl/tx_pkt_scheduler_if.sv
// AXI-Stream style payload channel with header sideband.
//   tdata/tvalid/tready/tlast : usual stream handshake
//   tuser : modulation flag (1 = BPSK, 0 = QPSK)
//   len   : payload length in bits, stable while tvalid is high
// On the scheduler output, len carries the latched payload_length and tuser
// the latched is_bpsk of the granted packet.
interface tx_pkt_scheduler_if
    import tx_pkt_scheduler_pkg::*;
#(
    parameter int BYTES = 1
);
    logic [BYTES*8-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               tuser;
    logic [LEN_W-1:0]   len;

    modport master (output tdata, tvalid, tlast, tuser, len, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, len, output tready);
endinterface

// File: rtl/tx_pkt_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request vector
//   adv      : commit the current winner as the last-granted source
//   win_idx  : index of the winning requester (valid when req != 0)
// last_grant resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       win_idx
);
    logic last_grant;

    always_comb begin
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            default: win_idx = ~last_grant;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      last_grant <= 1'b1;
        else if (adv) last_grant <= win_idx;
    end
endmodule

// File: rtl/tx_pkt_scheduler.sv
// Two-source TX scheduler in front of the packetizer. Grants one source at a
// time round-robin, latches its header, forwards exactly one packet with a
// generated tlast, waits for pkt_done from the packetizer, then holds an idle
// gap so the packetizer always sees tvalid low between packets.
//   clk, rst   : symbol clock, synchronous active-high reset
//   enable     : allows new grants (only looked at in IDLE)
//   s0, s1     : source streams (slave side)
//   m          : packetizer stream; m.len = payload_length, m.tuser = is_bpsk
//   pkt_done   : packetizer end-of-packet pulse
//   grant      : one-hot active source, busy : not IDLE
//   err_tlast  : source tlast disagreed with generated tlast
//   err_len    : zero-beat request rejected
//   pkt_count  : completed packets (wraps)
module tx_pkt_scheduler
    import tx_pkt_scheduler_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    tx_pkt_scheduler_if.slave    s0,
    tx_pkt_scheduler_if.slave    s1,
    tx_pkt_scheduler_if.master   m,
    input  logic                 pkt_done,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 err_tlast,
    output logic                 err_len,
    output logic [15:0]          pkt_count
);
    localparam int         DW     = BYTES * 8;
    localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);

    state_t           state, state_nxt;
    hdr_t             hdr_q;
    logic [LEN_W-1:0] beat_cnt;
    logic [7:0]       gap_cnt;

    logic [1:0]       req;
    logic             arb_go, win_idx, zero_req, accept;
    logic [LEN_W-1:0] win_len, win_beats;
    logic             win_bpsk;

    logic             sel, sel_tvalid, sel_tlast, last_beat, xfer;
    logic [DW-1:0]    sel_tdata;

    assign req    = {s1.tvalid, s0.tvalid};
    assign arb_go = (state == ST_IDLE) && enable && (req != 2'b00);

    // The arbiter advances on rejections too, so a zero-length source
    // cannot starve the other one.
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .adv     (arb_go),
        .win_idx (win_idx)
    );

    assign win_len   = win_idx ? s1.len   : s0.len;
    assign win_bpsk  = win_idx ? s1.tuser : s0.tuser;
    assign win_beats = beats_of(win_len, win_bpsk);
    assign zero_req  = arb_go && (win_beats == '0);
    assign accept    = arb_go && !zero_req;

    assign sel        = grant[1];
    assign sel_tdata  = sel ? s1.tdata  : s0.tdata;
    assign sel_tvalid = sel ? s1.tvalid : s0.tvalid;
    assign sel_tlast  = sel ? s1.tlast  : s0.tlast;
    assign last_beat  = (beat_cnt == 16'd1);
    assign xfer       = (state == ST_STREAM) && sel_tvalid && m.tready;

    assign busy    = (state != ST_IDLE);
    assign m.len   = hdr_q.len;
    assign m.tuser = hdr_q.is_bpsk;

    always_comb begin
        state_nxt = state;
        m.tdata   = '0;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_STREAM;
            ST_STREAM: begin
                m.tdata  = sel_tdata;
                m.tvalid = sel_tvalid;
                m.tlast  = last_beat;
                if (sel) s1.tready = m.tready;
                else     s0.tready = m.tready;
                if (xfer && last_beat) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  if (pkt_done) state_nxt = ST_GAP;
            ST_GAP:    if (gap_cnt == 8'd1) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= 2'b00;
            hdr_q     <= '{len: '0, is_bpsk: 1'b1};
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            pkt_count <= '0;
            err_tlast <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_len   <= zero_req;
            // Source tlast is only checked; the generated tlast sets length.
            err_tlast <= xfer && (sel_tlast != last_beat);
            case (state)
                ST_IDLE: if (accept) begin
                    grant    <= win_idx ? 2'b10 : 2'b01;
                    hdr_q    <= '{len: win_len, is_bpsk: win_bpsk};
                    beat_cnt <= win_beats;
                end
                ST_STREAM: if (xfer) beat_cnt <= beat_cnt - 16'd1;
                ST_DRAIN: if (pkt_done) begin
                    pkt_count <= pkt_count + 16'd1;
                    gap_cnt   <= GAP_LD;
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd1) grant <= 2'b00;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_pkt_scheduler.sv
module tb_tx_pkt_scheduler;
    localparam int GAP = 4;

    typedef struct {
        logic [15:0] len;
        logic        bpsk;
        logic [15:0] mask;   // bit i: source drives tlast on beat i
        int          nb;
        logic [3:0]  tag;
    } pkt_t;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [1:0]  grant;
        logic        tuser;
        logic [15:0] plen;
    } exp_t;

    typedef struct {
        int          src;
        logic [15:0] len;
        logic        bpsk;
        logic [15:0] mask;
        int          mode;   // 0: m_tready=1, 1: toggle, 2: random
        int          nb;
        int          etl;
        int          eln;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, enable, pkt_done;
    logic [1:0]  grant;
    logic        busy, err_tlast, err_len;
    logic [15:0] pkt_count;

    tx_pkt_scheduler_if #(.BYTES(1)) s0_if ();
    tx_pkt_scheduler_if #(.BYTES(1)) s1_if ();
    tx_pkt_scheduler_if #(.BYTES(1)) m_if ();

    tx_pkt_scheduler #(.BYTES(1), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .pkt_done  (pkt_done),
        .grant     (grant),
        .busy      (busy),
        .err_tlast (err_tlast),
        .err_len   (err_len),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    pkt_t sq0[$], sq1[$];
    exp_t sb[$];
    vec_t vt[9];
    int   cyc = 0, n_vec = 0, n_err = 0, n_beats = 0, n_etl = 0, n_eln = 0;
    int   pd_cyc = -1, idle_cyc = -1, first_v = -1, req_cyc = 0;
    int   pd_dly = 0, mode = 0, sidx0 = 0, sidx1 = 0, exp_count = 0;
    logic hs0, hs1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_srcs();
        if (sq0.size() > 0) begin
            s0_if.tvalid = 1'b1;
            s0_if.tdata  = {sq0[0].tag, 4'(sidx0)};
            s0_if.tlast  = sq0[0].mask[sidx0];
            s0_if.len    = sq0[0].len;
            s0_if.tuser  = sq0[0].bpsk;
        end else begin
            s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
            s0_if.len = '0; s0_if.tuser = 1'b0;
        end
        if (sq1.size() > 0) begin
            s1_if.tvalid = 1'b1;
            s1_if.tdata  = {sq1[0].tag, 4'(sidx1)};
            s1_if.tlast  = sq1[0].mask[sidx1];
            s1_if.len    = sq1[0].len;
            s1_if.tuser  = sq1[0].bpsk;
        end else begin
            s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
            s1_if.len = '0; s1_if.tuser = 1'b0;
        end
    endtask

    task automatic add_src(input int src, input logic [15:0] len, input logic bpsk,
                           input logic [15:0] mask, input int nb, input logic [3:0] tag);
        pkt_t p;
        p.len = len; p.bpsk = bpsk; p.mask = mask; p.nb = nb; p.tag = tag;
        if (src == 0) sq0.push_back(p);
        else          sq1.push_back(p);
        drive_srcs();
    endtask

    task automatic add_exp(input int src, input logic [15:0] len, input logic bpsk,
                           input int nb, input logic [3:0] tag);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.data  = {tag, 4'(b)};
            e.last  = (b == nb - 1);
            e.grant = (src == 0) ? 2'b01 : 2'b10;
            e.tuser = bpsk;
            e.plen  = len;
            sb.push_back(e);
        end
    endtask

    // Observe at negedge, then update stimulus just after the next posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        hs0 = s0_if.tvalid && s0_if.tready;
        hs1 = s1_if.tvalid && s1_if.tready;
        if (m_if.tvalid && sb.size() > 0) begin
            chk("s0_tready", 32'(s0_if.tready), 32'(sb[0].grant[0] & m_if.tready));
            chk("s1_tready", 32'(s1_if.tready), 32'(sb[0].grant[1] & m_if.tready));
        end
        if (m_if.tvalid && m_if.tready) begin
            n_beats++;
            chk("beat_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("m_tdata", 32'(m_if.tdata), 32'(e.data));
                chk("m_tlast", 32'(m_if.tlast), 32'(e.last));
                chk("grant", 32'(grant), 32'(e.grant));
                chk("m_tuser", 32'(m_if.tuser), 32'(e.tuser));
                chk("payload_length", 32'(m_if.len), 32'(e.plen));
            end
            if (m_if.tlast) pd_dly = 3;
        end
        if (err_tlast) n_etl++;
        if (err_len) n_eln++;
        if (m_if.tvalid && first_v < 0) first_v = cyc;
        if (pkt_done) pd_cyc = cyc;
        if (pd_cyc >= 0 && idle_cyc < 0 && !busy) idle_cyc = cyc;

        @(posedge clk);
        #1;
        if (hs0) begin
            sidx0++;
            if (sidx0 == sq0[0].nb) begin sq0.delete(0); sidx0 = 0; end
        end else if (sq0.size() > 0 && sq0[0].nb == 0) sq0.delete(0);
        if (hs1) begin
            sidx1++;
            if (sidx1 == sq1[0].nb) begin sq1.delete(0); sidx1 = 0; end
        end else if (sq1.size() > 0 && sq1[0].nb == 0) sq1.delete(0);
        case (mode)
            1:       m_if.tready = !m_if.tready;
            2:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b1;
        endcase
        pkt_done = 1'b0;
        if (pd_dly > 0) begin
            pd_dly--;
            if (pd_dly == 0) pkt_done = 1'b1;
        end
        drive_srcs();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(sb.size() == 0 && sq0.size() == 0 && sq1.size() == 0 &&
                 pd_dly == 0 && !busy) && n < budget) begin
            tick();
            n++;
        end
        chk("run_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_grant"}, 32'(grant), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_s0_tready"}, 32'(s0_if.tready), 32'd0);
        chk({t, "_s1_tready"}, 32'(s1_if.tready), 32'd0);
        chk({t, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
        chk({t, "_m_tlast"}, 32'(m_if.tlast), 32'd0);
        chk({t, "_err_tlast"}, 32'(err_tlast), 32'd0);
        chk({t, "_err_len"}, 32'(err_len), 32'd0);
        chk({t, "_m_tdata"}, 32'(m_if.tdata), 32'd0);
        chk({t, "_m_tuser"}, 32'(m_if.tuser), 32'd1);
        chk({t, "_payload_length"}, 32'(m_if.len), 32'd0);
        chk({t, "_pkt_count"}, 32'(pkt_count), 32'd0);
    endtask

    initial begin
        int n, nb0;
        //         src len     bpsk  mask      mode nb etl eln
        vt[0] = '{0, 16'd8,  1'b1, 16'h0080, 0, 8, 0, 0};  // BPSK 8 beats
        vt[1] = '{1, 16'd10, 1'b0, 16'h0010, 0, 5, 0, 0};  // QPSK 10 bits -> 5
        vt[2] = '{0, 16'd4,  1'b1, 16'h0008, 1, 4, 0, 0};  // toggling backpressure
        vt[3] = '{1, 16'd4,  1'b1, 16'h000A, 0, 4, 1, 0};  // early tlast on beat 2
        vt[4] = '{0, 16'd1,  1'b0, 16'h0000, 0, 0, 0, 1};  // QPSK 1 bit -> 0 beats
        vt[5] = '{1, 16'd16, 1'b0, 16'h0080, 2, 8, 0, 0};  // random backpressure
        vt[6] = '{0, 16'd3,  1'b0, 16'h0001, 1, 1, 0, 0};  // single beat
        vt[7] = '{0, 16'd2,  1'b1, 16'h0000, 0, 2, 1, 0};  // missing final tlast
        vt[8] = '{1, 16'd1,  1'b1, 16'h0001, 0, 1, 0, 0};  // leaves s1 as last grant

        rst = 1'b1; enable = 1'b1; pkt_done = 1'b0; m_if.tready = 1'b1;
        drive_srcs();
        repeat (3) tick();
        check_reset("init");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            n_etl = 0; n_eln = 0; pd_cyc = -1; idle_cyc = -1; first_v = -1;
            mode = vt[i].mode;
            req_cyc = cyc + 1;
            add_src(vt[i].src, vt[i].len, vt[i].bpsk, vt[i].mask, vt[i].nb, 4'(i + 1));
            add_exp(vt[i].src, vt[i].len, vt[i].bpsk, vt[i].nb, 4'(i + 1));
            if (vt[i].nb > 0) exp_count++;
            run_until_idle(400);
            repeat (2) tick();
            mode = 0;
            chk($sformatf("v%0d_pkt_count", i), 32'(pkt_count), 32'(exp_count));
            chk($sformatf("v%0d_err_tlast", i), 32'(n_etl), 32'(vt[i].etl));
            chk($sformatf("v%0d_err_len", i), 32'(n_eln), 32'(vt[i].eln));
            chk($sformatf("v%0d_grant_idle", i), 32'(grant), 32'd0);
            if (vt[i].nb > 0) begin
                chk($sformatf("v%0d_latency", i), 32'(first_v - req_cyc), 32'd2);
                chk($sformatf("v%0d_gap", i), 32'(idle_cyc - pd_cyc), 32'(GAP + 1));
            end else begin
                chk($sformatf("v%0d_no_beat", i), 32'(first_v), 32'hFFFF_FFFF);
            end
        end

        // Contention: both sources keep requesting; grants must alternate.
        n_etl = 0;
        for (int k = 0; k < 3; k++) begin
            add_src(0, 16'd6, 1'b1, 16'h0020, 6, 4'(9 + k));
            add_src(1, 16'd8, 1'b0, 16'h0008, 4, 4'(12 + k));
        end
        for (int k = 0; k < 3; k++) begin
            add_exp(0, 16'd6, 1'b1, 6, 4'(9 + k));
            add_exp(1, 16'd8, 1'b0, 4, 4'(12 + k));
        end
        exp_count += 6;
        run_until_idle(1500);
        repeat (2) tick();
        chk("rr_pkt_count", 32'(pkt_count), 32'(exp_count));
        chk("rr_err_tlast", 32'(n_etl), 32'd0);

        // pkt_done while IDLE must be ignored.
        pkt_done = 1'b1;
        repeat (4) tick();
        chk("stray_done_count", 32'(pkt_count), 32'(exp_count));
        chk("stray_done_busy", 32'(busy), 32'd0);

        // Reset in the middle of STREAM.
        add_src(0, 16'd8, 1'b1, 16'h0080, 8, 4'd15);
        add_exp(0, 16'd8, 1'b1, 8, 4'd15);
        n = 0; nb0 = n_beats;
        while (n_beats < nb0 + 3 && n < 50) begin tick(); n++; end
        chk("mid_reach_stream", 32'(n < 50), 32'd1);
        rst = 1'b1;
        sq0.delete(); sidx0 = 0; sb.delete(); pd_dly = 0;
        drive_srcs();
        tick();
        check_reset("mid");
        rst = 1'b0;
        exp_count = 0;

        // enable drops mid-packet: packet finishes, then no new grant.
        add_src(0, 16'd6, 1'b1, 16'h0020, 6, 4'd1);
        add_exp(0, 16'd6, 1'b1, 6, 4'd1);
        n = 0; nb0 = n_beats;
        while (n_beats == nb0 && n < 50) begin tick(); n++; end
        chk("en_reach_stream", 32'(n < 50), 32'd1);
        enable = 1'b0;
        add_src(1, 16'd4, 1'b1, 16'h0008, 4, 4'd2);
        add_exp(1, 16'd4, 1'b1, 4, 4'd2);
        n = 0;
        while (!(sq0.size() == 0 && !busy && pd_dly == 0) && n < 200) begin tick(); n++; end
        chk("en_first_done", 32'(n < 200), 32'd1);
        repeat (20) tick();
        chk("en_hold_busy", 32'(busy), 32'd0);
        chk("en_hold_grant", 32'(grant), 32'd0);
        chk("en_hold_pending", 32'(sb.size()), 32'd4);
        chk("en_hold_count", 32'(pkt_count), 32'd1);
        enable = 1'b1;
        run_until_idle(400);
        chk("en_resume_count", 32'(pkt_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
